updown_btn_ctrl: RTL and testbench
==================================

Name: updown_btn_ctrl

Overview:
- Upstream control stage for the up/down decade counter.
- Synchronizes and debounces two raw active-low push buttons.
- Converts clean presses into the counter's direction level DEC and a HOLD (pause) level, plus one-cycle press pulses.
- Drives active-low status LEDs so direction and hold state are visible on the board.

Parameters:
- SAMPLE_MAX, 60000, CLK cycles per debounce sample tick (10 ms at 6 MHz); legal range 2..2^20.
- STABLE_N, 4, consecutive identical samples required to change debounced state; legal range 2..8.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- BTN_DIR_N  in  1  raw direction button, 0 = pressed, asynchronous to CLK
- BTN_HOLD_N  in  1  raw hold button, 0 = pressed, asynchronous to CLK
- DEC  out  1  direction to counter: 1 = count up, 0 = count down
- HOLD  out  1  1 = counting paused (gates counter enable externally)
- DIR_PRESS  out  1  one-CLK pulse per debounced direction-button press
- HOLD_PRESS  out  1  one-CLK pulse per debounced hold-button press
- LED_N  out  2  active-low indicators: [0] = ~DEC, [1] = ~HOLD

Behaviour:
- Reset values (RESET=0, asynchronous): DEC=1, HOLD=0, DIR_PRESS=0, HOLD_PRESS=0, LED_N=2'b10.
- Reset clears internal state: tick counter = 0, synchronizers = 0, histories = 0, debounced levels = 0 (released).
- Synchronizer: each button is inverted to a pressed-high level, then passes two flops before any use.
- Tick counter:
  - Counts 0..SAMPLE_MAX-1 and wraps to 0.
  - TICK = 1 for exactly the cycle where the count equals SAMPLE_MAX-1.
  - Width is ceil(log2(SAMPLE_MAX)).
- History register, per button, STABLE_N bits:
  - On TICK, shifts in the synchronized pressed level.
  - On non-TICK cycles, holds.
- Debounced level, per button, updated only on TICK cycles:
  - Becomes 1 when the post-shift history is all ones.
  - Becomes 0 when the post-shift history is all zeros.
  - Otherwise holds its value.
- Press detect: the PRESS output is registered and asserts in the cycle after the debounced level goes 0->1, for exactly one cycle.
  - Release (1->0) produces no pulse.
  - A held button produces no further pulses.
- Toggles:
  - DEC inverts in the same cycle DIR_PRESS is 1.
  - HOLD inverts in the same cycle HOLD_PRESS is 1.
  - The two buttons are fully independent; simultaneous presses toggle both in the same cycle.
- Latency from a clean input edge to the PRESS pulse:
  - 2 sync cycles, then STABLE_N ticks, then 1 cycle.
  - Bounds are therefore 2 + (STABLE_N-1)*SAMPLE_MAX + 1 to 2 + STABLE_N*SAMPLE_MAX + 1 cycles.
- Glitch rejection: any bounce producing a mixed history never changes the debounced level, so it generates no pulse.
- LED_N is combinational from the DEC and HOLD registers; no extra latency.
- Reset mid-press: all state clears. A button still held at reset release must be seen stable for STABLE_N ticks before it is debounced as pressed. Once debounced, it then produces one pulse.

Test Plan (bench uses SAMPLE_MAX=4, STABLE_N=4):
- Reset: hold RESET=0 with buttons released -> DEC=1, HOLD=0, both pulses 0, LED_N=2'b10. Release reset and idle 100 cycles -> no change.
- Clean direction press: BTN_DIR_N=0 for 40 cycles, then 1 -> exactly one DIR_PRESS pulse, 15..19 cycles after the falling input edge. DEC=0 and LED_N[0]=1 from the pulse cycle; no pulse on release.
- Second press: repeat the clean press -> DEC returns to 1. Holding the button for 200 cycles gives no additional pulse.
- Bounce rejection: toggle BTN_DIR_N every 3 cycles for 60 cycles, ending released -> DIR_PRESS never asserts and DEC unchanged. The same bounce ending pressed and then held stable -> exactly one pulse.
- Simultaneous presses: both buttons go low in the same cycle for 40 cycles -> DIR_PRESS and HOLD_PRESS pulse in the same cycle. DEC and HOLD both invert; LED_N reflects both.
- Reset mid-press: assert RESET while BTN_HOLD_N=0 and the debounce is half complete, deassert with the button still held -> HOLD=0 at reset. One HOLD_PRESS pulse arrives 15..19 cycles after reset release, then HOLD=1.

Source files
------------

// File: rtl/updown_btn_ctrl_if.sv
// Button-side and counter-side signals of the up/down control stage.
// The control block takes the slave view; whatever drives the buttons
// and consumes DEC/HOLD takes the master view.
interface updown_btn_ctrl_if;
  logic       BTN_DIR_N;
  logic       BTN_HOLD_N;
  logic       DEC;
  logic       HOLD;
  logic       DIR_PRESS;
  logic       HOLD_PRESS;
  logic [1:0] LED_N;

  modport master (
    output BTN_DIR_N, BTN_HOLD_N,
    input  DEC, HOLD, DIR_PRESS, HOLD_PRESS, LED_N
  );

  modport slave (
    input  BTN_DIR_N, BTN_HOLD_N,
    output DEC, HOLD, DIR_PRESS, HOLD_PRESS, LED_N
  );
endinterface

// File: rtl/updown_btn_ctrl.sv
// Up/down counter control stage: synchronizes and debounces two raw
// active-low buttons, turns clean presses into one-cycle pulses and
// toggles the DEC (direction) and HOLD (pause) levels, with
// active-low LEDs mirroring both levels.
// Button index 0 is the direction button, index 1 the hold button.
module updown_btn_ctrl #(
  parameter int SAMPLE_MAX = 60000,
  parameter int STABLE_N   = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  updown_btn_ctrl_if.slave btn_if
);

  localparam int               CNT_W    = $clog2(SAMPLE_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic [1:0]       btn_raw_n;
  logic [1:0]       press_d, press_q;
  logic             dec_d, dec_q;
  logic             hold_d, hold_q;

  assign btn_raw_n = {btn_if.BTN_HOLD_N, btn_if.BTN_DIR_N};

  // Free-running sample divider; tick marks the last count of each period.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Sample divider register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic                sync1_q, sync2_q;
      logic [STABLE_N-1:0] hist_q, hist_d;
      logic                deb_q, deb_d;
      logic                deb_prev_q;

      // History shifts only on ticks; the level follows a unanimous history
      // and otherwise keeps its value, so mixed (bouncing) samples are ignored.
      always_comb begin
        hist_d = hist_q;
        deb_d  = deb_q;
        if (tick) begin
          hist_d = {hist_q[STABLE_N-2:0], sync2_q};
          if (&hist_d)       deb_d = 1'b1;
          else if (~|hist_d) deb_d = 1'b0;
        end
      end

      // Rising edge of the registered debounced level, one cycle after it rises.
      assign press_d[gi] = deb_q & ~deb_prev_q;

      // Two-flop synchronizer (inverted to pressed-high) and debounce state.
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          sync1_q    <= 1'b0;
          sync2_q    <= 1'b0;
          hist_q     <= '0;
          deb_q      <= 1'b0;
          deb_prev_q <= 1'b0;
        end else begin
          sync1_q    <= ~btn_raw_n[gi];
          sync2_q    <= sync1_q;
          hist_q     <= hist_d;
          deb_q      <= deb_d;
          deb_prev_q <= deb_q;
        end
      end
    end
  endgenerate

  // Each level toggles in the very cycle its press pulse is visible.
  always_comb begin
    dec_d  = dec_q ^ press_d[0];
    hold_d = hold_q ^ press_d[1];
  end

  // Press pulses and the direction/hold levels; reset means count up, running.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      press_q <= 2'b00;
      dec_q   <= 1'b1;
      hold_q  <= 1'b0;
    end else begin
      press_q <= press_d;
      dec_q   <= dec_d;
      hold_q  <= hold_d;
    end
  end

  assign btn_if.DEC        = dec_q;
  assign btn_if.HOLD       = hold_q;
  assign btn_if.DIR_PRESS  = press_q[0];
  assign btn_if.HOLD_PRESS = press_q[1];
  assign btn_if.LED_N      = {~hold_q, ~dec_q};

endmodule

// File: tb/tb_updown_btn_ctrl.sv
// Bench for updown_btn_ctrl with SAMPLE_MAX=4, STABLE_N=4. Every cycle is
// compared with a model that keeps the whole sampled input trace since
// reset and derives the debounced level from the samples seen on tick
// cycles; table segments and hand sequences add pulse-count, latency and
// level checks with constant expectations.
module tb_updown_btn_ctrl;
  localparam int SM   = 4;
  localparam int SN   = 4;
  localparam int MAXC = 4096;
  localparam int RST_VEC = 34; // {DEC,HOLD,DIR_PRESS,HOLD_PRESS,LED_N} = 1,0,0,0,2'b10

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  updown_btn_ctrl_if btn();

  updown_btn_ctrl #(.SAMPLE_MAX(SM), .STABLE_N(SN)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .btn_if (btn)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string name;
    bit    dir_n;
    bit    hold_n;
    int    cycles;
    int    exp_dp;
    int    exp_hp;
    bit    exp_dec;
    bit    exp_hold;
  } seg_t;

  int       n_checks = 0;
  int       n_errors = 0;
  int       cyc;
  bit       in_b  [2][MAXC];
  bit       deb_b [2][MAXC];
  bit       exp_dec, exp_hold;
  bit [1:0] exp_pr;
  bit       obs_dp, obs_hp;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: the pressed level sampled at edge k reaches the history at the
  // tick edge k+2; the debounced level takes the value of the last SN tick
  // samples when they agree; the pulse shows one edge after the level rises.
  function automatic void model_edge(input bit p_dir, input bit p_hold);
    bit [1:0] v;
    bit       ones, zeros, s;
    int       k;
    v = {p_hold, p_dir};
    for (int b = 0; b < 2; b++) begin
      in_b[b][cyc] = v[b];
      ones  = 1'b1;
      zeros = 1'b1;
      for (int j = 0; j < SN; j++) begin
        k = cyc - 2 - SM * j;
        s = (k >= 1) ? in_b[b][k] : 1'b0;
        if (s) zeros = 1'b0;
        else   ones  = 1'b0;
      end
      deb_b[b][cyc] = deb_b[b][cyc-1];
      if (cyc % SM == 0) begin
        if (ones)       deb_b[b][cyc] = 1'b1;
        else if (zeros) deb_b[b][cyc] = 1'b0;
      end
      exp_pr[b] = (cyc >= 2) && deb_b[b][cyc-1] && !deb_b[b][cyc-2];
    end
    exp_dec  = exp_dec ^ exp_pr[0];
    exp_hold = exp_hold ^ exp_pr[1];
  endfunction

  // One clock: drive at the falling edge, model the rising edge, compare at the next falling edge.
  task automatic step(input bit d_n, input bit h_n);
    if (cyc >= MAXC - 1) begin
      $display("FAIL model_range: cycle %0d reached limit %0d", cyc, MAXC);
      $fatal(1);
    end
    btn.BTN_DIR_N  = d_n;
    btn.BTN_HOLD_N = h_n;
    @(posedge CLK);
    cyc++;
    model_edge(!d_n, !h_n);
    @(negedge CLK);
    obs_dp = btn.DIR_PRESS;
    obs_hp = btn.HOLD_PRESS;
    chk("model", int'({btn.DEC, btn.HOLD, btn.DIR_PRESS, btn.HOLD_PRESS, btn.LED_N}),
        int'({exp_dec, exp_hold, exp_pr[0], exp_pr[1], ~exp_hold, ~exp_dec}));
  endtask

  // Hold both buttons steady for n cycles; report pulse counts and first pulse step (-1 if none).
  task automatic run_n(input int n, input bit d_n, input bit h_n,
                       output int dp, output int hp, output int fd, output int fh);
    dp = 0; hp = 0; fd = -1; fh = -1;
    for (int t = 1; t <= n; t++) begin
      step(d_n, h_n);
      if (obs_dp) begin dp++; if (fd < 0) fd = t; end
      if (obs_hp) begin hp++; if (fh < 0) fh = t; end
    end
  endtask

  // Direction button toggled every 3 cycles for 60 cycles, starting at start_n.
  task automatic bounce(input bit start_n, output int dp);
    dp = 0;
    for (int i = 0; i < 60; i++) begin
      step(((i / 3) % 2 == 0) ? start_n : ~start_n, 1'b1);
      if (obs_dp) dp++;
    end
  endtask

  // Asynchronous reset entered at a falling edge, released n falling edges later.
  task automatic do_reset(input int n, input bit d_n, input bit h_n);
    btn.BTN_DIR_N  = d_n;
    btn.BTN_HOLD_N = h_n;
    RESET = 1'b0;
    #1;
    chk("reset_async", int'({btn.DEC, btn.HOLD, btn.DIR_PRESS, btn.HOLD_PRESS, btn.LED_N}), RST_VEC);
    repeat (n) @(negedge CLK);
    chk("reset_held", int'({btn.DEC, btn.HOLD, btn.DIR_PRESS, btn.HOLD_PRESS, btn.LED_N}), RST_VEC);
    RESET    = 1'b1;
    cyc      = 0;
    exp_dec  = 1'b1;
    exp_hold = 1'b0;
    exp_pr   = 2'b00;
    deb_b[0][0] = 1'b0;
    deb_b[1][0] = 1'b0;
  endtask

  seg_t segs [9];

  initial begin
    int dp, hp, fd, fh, tot, len, t;
    bit rd, rh;

    segs[0] = '{"idle",        1'b1, 1'b1, 100, 0, 0, 1'b1, 1'b0};
    segs[1] = '{"dir_press1",  1'b0, 1'b1,  40, 1, 0, 1'b0, 1'b0};
    segs[2] = '{"dir_rel1",    1'b1, 1'b1,  40, 0, 0, 1'b0, 1'b0};
    segs[3] = '{"dir_held200", 1'b0, 1'b1, 200, 1, 0, 1'b1, 1'b0};
    segs[4] = '{"dir_rel2",    1'b1, 1'b1,  40, 0, 0, 1'b1, 1'b0};
    segs[5] = '{"hold_press",  1'b1, 1'b0,  40, 0, 1, 1'b1, 1'b1};
    segs[6] = '{"hold_rel",    1'b1, 1'b1,  40, 0, 0, 1'b1, 1'b1};
    segs[7] = '{"both_press",  1'b0, 1'b0,  40, 1, 1, 1'b0, 1'b0};
    segs[8] = '{"both_rel",    1'b1, 1'b1,  40, 0, 0, 1'b0, 1'b0};

    btn.BTN_DIR_N  = 1'b1;
    btn.BTN_HOLD_N = 1'b1;
    cyc = 0;
    @(negedge CLK);
    do_reset(5, 1'b1, 1'b1);

    for (int i = 0; i < 9; i++) begin
      run_n(segs[i].cycles, segs[i].dir_n, segs[i].hold_n, dp, hp, fd, fh);
      chk({segs[i].name, "_dir_pulses"}, dp, segs[i].exp_dp);
      chk({segs[i].name, "_hold_pulses"}, hp, segs[i].exp_hp);
      chk({segs[i].name, "_dec"}, int'(btn.DEC), int'(segs[i].exp_dec));
      chk({segs[i].name, "_hold"}, int'(btn.HOLD), int'(segs[i].exp_hold));
      chk({segs[i].name, "_led_n"}, int'(btn.LED_N), int'({~segs[i].exp_hold, ~segs[i].exp_dec}));
      if (segs[i].exp_dp > 0) chk({segs[i].name, "_dir_latency_in_15_19"}, int'(fd >= 15 && fd <= 19), 1);
      if (segs[i].exp_hp > 0) chk({segs[i].name, "_hold_latency_in_15_19"}, int'(fh >= 15 && fh <= 19), 1);
      if (segs[i].exp_dp > 0 && segs[i].exp_hp > 0) chk({segs[i].name, "_same_cycle"}, fd, fh);
      $display("seg %0d %s: dir_pulses=%0d hold_pulses=%0d first_dir=%0d first_hold=%0d DEC=%0b HOLD=%0b LED_N=%b",
               i, segs[i].name, dp, hp, fd, fh, btn.DEC, btn.HOLD, btn.LED_N);
    end

    // Bounce ending released: no pulse, DEC stays 0.
    bounce(1'b0, tot);
    run_n(40, 1'b1, 1'b1, dp, hp, fd, fh);
    tot += dp;
    chk("bounce_released_pulses", tot, 0);
    chk("bounce_released_dec", int'(btn.DEC), 0);
    $display("bounce ending released: dir_pulses=%0d DEC=%0b", tot, btn.DEC);

    // Bounce ending pressed and held: exactly one pulse, DEC back to 1.
    bounce(1'b1, tot);
    run_n(60, 1'b0, 1'b1, dp, hp, fd, fh);
    tot += dp;
    run_n(40, 1'b1, 1'b1, dp, hp, fd, fh);
    tot += dp;
    chk("bounce_pressed_pulses", tot, 1);
    chk("bounce_pressed_dec", int'(btn.DEC), 1);
    $display("bounce ending pressed: dir_pulses=%0d DEC=%0b", tot, btn.DEC);

    // Set HOLD=1 so the mid-press reset visibly clears it.
    run_n(40, 1'b1, 1'b0, dp, hp, fd, fh);
    run_n(40, 1'b1, 1'b1, dp, tot, fd, fh);
    chk("hold_set_pulses", hp + tot, 1);
    chk("hold_set_level", int'(btn.HOLD), 1);

    // Reset half way through a hold press, released with the button still held.
    run_n(10, 1'b1, 1'b0, dp, hp, fd, fh);
    chk("midpress_no_pulse_yet", hp, 0);
    do_reset(3, 1'b1, 1'b0);
    run_n(40, 1'b1, 1'b0, dp, hp, fd, fh);
    chk("midpress_hold_pulses", hp, 1);
    chk("midpress_latency_in_15_19", int'(fh >= 15 && fh <= 19), 1);
    chk("midpress_hold_level", int'(btn.HOLD), 1);
    chk("midpress_led_n", int'(btn.LED_N), 0);
    $display("reset mid-press: hold_pulses=%0d first_hold=%0d HOLD=%0b LED_N=%b", hp, fh, btn.HOLD, btn.LED_N);
    run_n(40, 1'b1, 1'b1, dp, hp, fd, fh);

    // Random button activity against the model.
    t = 0;
    while (t < 1500) begin
      rd  = 1'($urandom_range(0, 1));
      rh  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 25));
      run_n(len, rd, rh, dp, hp, fd, fh);
      $display("random run: dir_n=%0b hold_n=%0b cycles=%0d dir_pulses=%0d hold_pulses=%0d DEC=%0b HOLD=%0b",
               rd, rh, len, dp, hp, btn.DEC, btn.HOLD);
      t += len;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
